adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 150 +++++++++++++++
 tb/tb_adder_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - two-requester arbitrated 8-bit adder with a fixed EXEC latency.
// Define ADDER_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module adder_arbiter #(
  parameter int ADD_LATENCY = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic       cin0,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  input  logic       cin1,
  output logic       grant0,
  output logic       grant1,
  output logic       busy,
  output logic       result_valid,
  output logic       result_owner,
  output logic [7:0] sum,
  output logic       overflow
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic        cin_q, cin_d;
  logic        op_owner_q, op_owner_d;
  logic        grant0_q, grant0_d;
  logic        grant1_q, grant1_d;
  logic        result_valid_q, result_valid_d;
  logic        result_owner_q, result_owner_d;
  logic [7:0]  sum_q, sum_d;
  logic        overflow_q, overflow_d;
  logic        any_req;
  logic        winner;
  logic [8:0]  full_sum;

`ifdef ADDER_ARB_FIXED_PRIO_EN
  assign winner = ~req0;
`else
  logic last_q, last_d;

  // On a tie the requester not granted last wins; last_q resets to 1 so requester 0 wins first.
  assign winner = (req0 && req1) ? ~last_q : req1;

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && any_req) last_d = winner;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`endif

  assign any_req  = req0 | req1;
  assign full_sum = {1'b0, a_q} + {1'b0, b_q} + {8'b0, cin_q};

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q        <= IDLE;
      cnt_q          <= 4'd0;
      a_q            <= 8'd0;
      b_q            <= 8'd0;
      cin_q          <= 1'b0;
      op_owner_q     <= 1'b0;
      grant0_q       <= 1'b0;
      grant1_q       <= 1'b0;
      result_valid_q <= 1'b0;
      result_owner_q <= 1'b0;
      sum_q          <= 8'd0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      a_q            <= a_d;
      b_q            <= b_d;
      cin_q          <= cin_d;
      op_owner_q     <= op_owner_d;
      grant0_q       <= grant0_d;
      grant1_q       <= grant1_d;
      result_valid_q <= result_valid_d;
      result_owner_q <= result_owner_d;
      sum_q          <= sum_d;
      overflow_q     <= overflow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = EXEC;
      EXEC:    if (cnt_q == 4'd1) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d          = cnt_q;
    a_d            = a_q;
    b_d            = b_q;
    cin_d          = cin_q;
    op_owner_d     = op_owner_q;
    grant0_d       = 1'b0;
    grant1_d       = 1'b0;
    result_valid_d = 1'b0;
    result_owner_d = result_owner_q;
    sum_d          = sum_q;
    overflow_d     = overflow_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          a_d        = winner ? a1 : a0;
          b_d        = winner ? b1 : b0;
          cin_d      = winner ? cin1 : cin0;
          op_owner_d = winner;
          grant0_d   = ~winner;
          grant1_d   = winner;
          cnt_d      = 4'(ADD_LATENCY);
        end
      end
      EXEC: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          sum_d          = full_sum[7:0];
          overflow_d     = full_sum[8];
          result_owner_d = op_owner_q;
          result_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign grant0       = grant0_q;
  assign grant1       = grant1_q;
  assign busy         = (state_q != IDLE);
  assign result_valid = result_valid_q;
  assign result_owner = result_owner_q;
  assign sum          = sum_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - directed and randomized checks of adder_arbiter against an operation-level model.
module tb_adder_arbiter;
  localparam int L = 2;

  logic       clk = 1'b0;
  logic       n_rst, req0, req1, cin0, cin1;
  logic [7:0] a0, b0, a1, b1;
  logic       grant0, grant1, busy, result_valid, result_owner, overflow;
  logic [7:0] sum;

  always #5 clk = ~clk;

  adder_arbiter #(.ADD_LATENCY(L)) dut (
    .clk(clk), .n_rst(n_rst),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .cin0(cin0),
    .a1(a1), .b1(b1), .cin1(cin1),
    .grant0(grant0), .grant1(grant1), .busy(busy),
    .result_valid(result_valid), .result_owner(result_owner),
    .sum(sum), .overflow(overflow)
  );

  int checks = 0;
  int errors = 0;

  // Model: an operation is granted, its result appears L edges later, then one more edge returns to idle.
  bit         m_idle = 1'b1;
  int         m_left = 0;
  bit         m_last = 1'b1;
  logic [8:0] m_pend = '0;
  bit         m_pown = 1'b0;
  bit         eg0, eg1, erv, eovf, eown;
  logic [7:0] esum;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    bit w;
    if (!n_rst) begin
      m_idle = 1; m_left = 0; m_last = 1;
      eg0 = 0; eg1 = 0; erv = 0; esum = 0; eovf = 0; eown = 0;
    end else begin
      eg0 = 0; eg1 = 0; erv = 0;
      if (m_idle) begin
        if (req0 || req1) begin
`ifdef ADDER_ARB_FIXED_PRIO_EN
          w = !req0;
`else
          w = (req0 && req1) ? !m_last : req1;
`endif
          m_last = w;
          m_pend = w ? (9'(a1) + 9'(b1) + 9'(cin1)) : (9'(a0) + 9'(b0) + 9'(cin0));
          m_pown = w;
          eg0 = !w; eg1 = w;
          m_idle = 0;
          m_left = L;
        end
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          erv = 1; esum = m_pend[7:0]; eovf = m_pend[8]; eown = m_pown;
        end
      end else begin
        m_idle = 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("grant0", grant0, eg0);
    chk("grant1", grant1, eg1);
    chk("grant_excl", grant0 & grant1, 0);
    chk("busy", busy, !m_idle);
    chk("result_valid", result_valid, erv);
    chk("sum", sum, esum);
    chk("overflow", overflow, eovf);
    chk("result_owner", result_owner, eown);
  endtask

  initial begin
    int g0_cnt, g1_cnt;
    n_rst = 0; req0 = 1; req1 = 1;
    a0 = 8'h11; b0 = 8'h22; cin0 = 0; a1 = 8'h33; b1 = 8'h44; cin1 = 1;
    step(); step();

    // Single op with carry-out wrap.
    n_rst = 1; req1 = 0; req0 = 1; a0 = 8'hFF; b0 = 8'h01; cin0 = 0;
    step();
    chk("r29_grant0", grant0, 1);
    req0 = 0; a0 = 8'h5A;
    step(); step();
    chk("r29_rv", result_valid, 1);
    chk("r29_sum", sum, 8'h00);
    chk("r29_ovf", overflow, 1);
    step();
    chk("r29_idle", busy, 0);

    // Tie after reset: requester 0 first, requester 1 at edge 5.
    n_rst = 0; step();
    n_rst = 1; req0 = 1; req1 = 1;
    a0 = 8'h10; b0 = 8'h20; cin0 = 1; a1 = 8'h80; b1 = 8'h80; cin1 = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 1) chk("r30_first", {grant1, grant0}, 2'b01);
      if (i == 3) chk("r30_sum0", {overflow, sum}, 9'h031);
      if (i == 5) chk("r30_second", {grant1, grant0}, 2'b10);
      if (i == 7) chk("r30_sum1", {result_owner, overflow, sum}, 10'h300);
      if (eg0) req0 = 0;
      if (eg1) req1 = 0;
    end

    // Both held for six operations.
    req0 = 1; req1 = 1; g0_cnt = 0; g1_cnt = 0;
    for (int i = 0; i < 6 * (L + 2); i++) begin
      step();
      g0_cnt += eg0; g1_cnt += eg1;
    end
`ifdef ADDER_ARB_FIXED_PRIO_EN
    chk("fair_g1", g1_cnt, 0);
`else
    chk("fair_g1", g1_cnt, 3);
`endif
    chk("fair_total", g0_cnt + g1_cnt, 6);
    req0 = 0;
    for (int i = 0; i < L + 2; i++) step();
    req1 = 0;
    for (int i = 0; i < L + 2; i++) step();

    // Abort: reset one cycle after grant1, held req1 granted again after release.
    req1 = 1; a1 = 8'hC3; b1 = 8'h7E; cin1 = 1;
    for (int i = 0; i < 10 && !eg1; i++) step();
    chk("abort_got_grant", eg1, 1);
    step();
    n_rst = 0; step();
    chk("abort_sum", sum, 8'h00);
    n_rst = 1;
    for (int i = 0; i < L + 3; i++) step();
    req1 = 0;
    for (int i = 0; i < L + 2; i++) step();

    // Randomized traffic with occasional resets and operand churn after grants.
    for (int i = 0; i < 400; i++) begin
      n_rst = ($urandom_range(0, 49) != 0);
      step();
      if (eg0 || (!req0 && $urandom_range(0, 2) == 0)) begin
        req0 = eg0 ? ($urandom_range(0, 3) != 0) : 1'b1;
        a0 = 8'($urandom); b0 = 8'($urandom); cin0 = 1'($urandom);
      end
      if (eg1 || (!req1 && $urandom_range(0, 2) == 0)) begin
        req1 = eg1 ? ($urandom_range(0, 3) != 0) : 1'b1;
        a1 = 8'($urandom); b1 = 8'($urandom); cin1 = 1'($urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
